add_sub: RTL and testbench

// - Signed add/subtract of two 3-bit sign-magnitude operands; 4-bit sign-magnitude result.
// - Arithmetic core of the 3-bit signed calculator, between operand capture and result display.
// - Result registered: one clock of latency.
//

---
 rtl/add_sub_pkg.sv | 11 +
 rtl/add_sub_sm3_to_tc4.sv | 17 +
 rtl/add_sub.sv | 46 ++++
 tb/tb_add_sub.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/add_sub_pkg.sv
// Shared types and constants for the 3-bit sign-magnitude calculator datapath.
package add_sub_pkg;

    typedef logic [2:0] sm3_t;  // [2] sign (1 = negative), [1:0] magnitude
    typedef logic [3:0] sm4_t;  // [3] sign (1 = negative), [2:0] magnitude

    localparam logic OP_ADD   = 1'b0;
    localparam logic OP_SUB   = 1'b1;
    localparam sm4_t SM_ZERO4 = 4'b0000;

endpackage

// File: rtl/add_sub_sm3_to_tc4.sv
// Converts a 3-bit sign-magnitude operand to 4-bit two's complement.
module sm3_to_tc4
    import add_sub_pkg::*;
(
    input  sm3_t       sm,
    output logic [3:0] tc
);

    logic [3:0] mag;

    // Negative zero (3'b100) negates 0 to 0, so it needs no special case.
    always_comb begin
        mag = {2'b00, sm[1:0]};
        tc  = sm[2] ? (~mag + 4'd1) : mag;
    end

endmodule

// File: rtl/add_sub.sv
// Signed add/subtract of two sign-magnitude operands; registered sign-magnitude result.
module add_sub
    import add_sub_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  sm3_t A,
    input  sm3_t B,
    input  logic op,
    output sm4_t C
);

    logic [3:0] a_tc;
    logic [3:0] b_tc;
    logic [3:0] b_eff;
    logic [3:0] sum;
    logic [3:0] sum_mag;
    sm4_t       c_next;

    sm3_to_tc4 u_conv_a (.sm(A), .tc(a_tc));
    sm3_to_tc4 u_conv_b (.sm(B), .tc(b_tc));

    // Subtract reuses the adder: a + ~b + 1, with the +1 as carry-in.
    always_comb begin
        b_eff = (op == OP_SUB) ? ~b_tc : b_tc;
        sum   = a_tc + b_eff + {3'b000, op};
    end

    always_comb begin
        sum_mag = sum[3] ? (~sum + 4'd1) : sum;
        if (sum_mag[2:0] == 3'd0) begin
            c_next = SM_ZERO4;
        end else begin
            c_next = {sum[3], sum_mag[2:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            C <= SM_ZERO4;
        end else begin
            C <= c_next;
        end
    end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub: directed cases, latency, exhaustive sweep and random stimulus.
module tb_add_sub;

    logic       clk;
    logic       rst;
    logic [2:0] A;
    logic [2:0] B;
    logic       op;
    logic [3:0] C;

    int checks   = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    add_sub dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .op  (op),
        .C   (C)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model: decode to integers, add or subtract, re-encode
    function automatic logic [3:0] model(input logic [2:0] a, input logic [2:0] b, input logic o);
        int va;
        int vb;
        int s;
        int m;
        logic [3:0] r;
        va = int'(a[1:0]);
        vb = int'(b[1:0]);
        if (a[2]) va = -va;
        if (b[2]) vb = -vb;
        s = o ? (va - vb) : (va + vb);
        m = (s < 0) ? -s : s;
        r = {(s < 0) ? 1'b1 : 1'b0, m[2:0]};
        return r;
    endfunction

    task automatic check(input string name, input logic [3:0] actual, input logic [3:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %b expected %b (A=%b B=%b op=%b t=%0t)",
                     name, actual, expected, A, B, op, $time);
        end
    endtask

    // driver: apply inputs mid-cycle and queue the result due after the next edge
    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic o, input logic [3:0] expected);
        @(negedge clk);
        A  = a;
        B  = b;
        op = o;
        exp_q.push_back(expected);
    endtask

    // scoreboard compare process
    initial begin
        logic [3:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pipe", C, e);
            end
        end
    end

    initial begin
        logic [2:0] ra;
        logic [2:0] rb;
        logic       ro;
        rst = 1'b1;
        A   = 3'b011;
        B   = 3'b011;
        op  = 1'b0;
        #1;
        check("reset_state", C, 4'b0000);

        // pin the model with hand-computed literals
        check("model_p3_plus_p3",   model(3'b011, 3'b011, 1'b0), 4'b0110);
        check("model_m3_plus_m3",   model(3'b111, 3'b111, 1'b0), 4'b1110);
        check("model_p2_minus_m3",  model(3'b010, 3'b111, 1'b1), 4'b0101);
        check("model_negzero",      model(3'b100, 3'b100, 1'b1), 4'b0000);

        @(posedge clk);
        #1;
        check("reset_hold", C, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // directed cases with literal expectations
        drive(3'b011, 3'b011, 1'b0, 4'b0110);
        drive(3'b111, 3'b111, 1'b0, 4'b1110);
        drive(3'b111, 3'b011, 1'b1, 4'b1110);
        drive(3'b010, 3'b111, 1'b1, 4'b0101);
        drive(3'b101, 3'b001, 1'b0, 4'b0000);
        drive(3'b100, 3'b100, 1'b1, 4'b0000);
        drive(3'b011, 3'b111, 1'b1, 4'b0110);
        drive(3'b100, 3'b010, 1'b1, 4'b1010);
        drive(3'b011, 3'b011, 1'b0, 4'b0110);

        // asynchronous reset asserted mid-cycle
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset", C, 4'b0000);
        @(posedge clk);
        #1;
        check("reset_held_over_edge", C, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        drive(3'b011, 3'b011, 1'b0, 4'b0110);

        // exhaustive sweep, inputs change every cycle
        for (int i = 0; i < 128; i++) begin
            logic [6:0] v;
            v = 7'(i);
            drive(v[6:4], v[3:1], v[0], model(v[6:4], v[3:1], v[0]));
        end

        // random stimulus
        for (int i = 0; i < 200; i++) begin
            ra = 3'($urandom_range(0, 7));
            rb = 3'($urandom_range(0, 7));
            ro = 1'($urandom_range(0, 1));
            drive(ra, rb, ro, model(ra, rb, ro));
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
